// File: rtl/misaligned_load_unit.sv
// Load unit: RISC-V load sizing and sign/zero extension, with
// misaligned loads split into two aligned memory beats.
module misaligned_load_unit #(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [4:0]      req_rd_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            fault_o
);

  localparam int B  = XLEN / 8;
  localparam int OW = $clog2(B);

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic            split_q, split_d;
  logic [XLEN-1:0] beat0_q, beat0_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            fault_q, fault_d;

  // Incoming request decode
  logic [4:0] req_off;
  logic [4:0] req_bytes;
  logic       req_split;
  logic       req_bad_op;
  logic       req_fault;

  always_comb begin
    req_off    = 5'(req_addr_i[OW-1:0]);
    req_bytes  = 5'd1 << req_funct3_i[1:0];
    req_split  = (req_off + req_bytes) > 5'(B);
    req_bad_op = (req_funct3_i == 3'b111);
    if (XLEN == 32) begin
      if (req_funct3_i == 3'b011 || req_funct3_i == 3'b110) begin
        req_bad_op = 1'b1;
      end
    end
    req_fault  = req_bad_op | (req_split & ~MISALIGN_EN);
  end

  // Beat merge, byte select and extension
  logic [2*XLEN-1:0] cat;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   merged;
  logic              sbit;
  logic              ext;
  int                nbytes;

  always_comb begin
    if (split_q) begin
      cat = {mem_rdata_i, beat0_q};
    end else begin
      cat = {{XLEN{1'b0}}, mem_rdata_i};
    end
    shifted = XLEN'(cat >> {addr_q[OW-1:0], 3'b000});
    nbytes  = 1 << f3_q[1:0];
    unique case (f3_q[1:0])
      2'b00:   sbit = shifted[7];
      2'b01:   sbit = shifted[15];
      2'b10:   sbit = shifted[31];
      default: sbit = shifted[XLEN-1];
    endcase
    ext    = sbit & ~f3_q[2];
    merged = '0;
    for (int i = 0; i < B; i++) begin
      if (i < nbytes) begin
        merged[8*i +: 8] = shifted[8*i +: 8];
      end else begin
        merged[8*i +: 8] = {8{ext}};
      end
    end
  end

  logic [XLEN-1:0] addr_al;

  always_comb begin
    addr_al = {addr_q[XLEN-1:OW], {OW{1'b0}}};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      split_q <= 1'b0;
      beat0_q <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      split_q <= split_d;
      beat0_q <= beat0_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    split_d = split_q;
    beat0_d = beat0_q;
    data_d  = data_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          f3_d    = req_funct3_i;
          rd_d    = req_rd_i;
          split_d = req_split;
          beat0_d = '0;
          data_d  = '0;
          fault_d = req_fault;
          state_d = req_fault ? RESP : REQ0;
        end
      end
      REQ0: begin
        if (mem_gnt_i) begin
          state_d = WAIT0;
        end
      end
      WAIT0: begin
        if (mem_rvalid_i) begin
          beat0_d = mem_rdata_i;
          if (split_q) begin
            state_d = REQ1;
          end else begin
            data_d  = merged;
            state_d = RESP;
          end
        end
      end
      REQ1: begin
        if (mem_gnt_i) begin
          state_d = WAIT1;
        end
      end
      WAIT1: begin
        if (mem_rvalid_i) begin
          data_d  = merged;
          state_d = RESP;
        end
      end
      RESP: begin
        if (wb_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    wb_valid_o  = 1'b0;
    wb_rd_o     = '0;
    wb_data_o   = '0;
    fault_o     = 1'b0;
    unique case (state_q)
      IDLE: req_ready_o = 1'b1;
      REQ0: begin
        mem_req_o  = 1'b1;
        mem_addr_o = addr_al;
      end
      REQ1: begin
        mem_req_o  = 1'b1;
        mem_addr_o = addr_al + XLEN'(B);
      end
      RESP: begin
        wb_valid_o = 1'b1;
        wb_rd_o    = rd_q;
        wb_data_o  = data_q;
        fault_o    = fault_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/misaligned_load_unit.md
MISALIGNED_LOAD_UNIT -- requirements
Module: misaligned_load_unit

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 or 64; B = XLEN/8 bytes per memory word.
REQ-002 Parameter MISALIGN_EN, default 1; 1 = split misaligned loads into two beats, 0 = raise fault on misaligned loads.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid_i  in  1  load request valid.
REQ-006 req_ready_o  out  1  unit can accept a request.
REQ-007 req_addr_i  in  XLEN  byte address.
REQ-008 req_funct3_i  in  3  RISC-V load funct3: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110.
REQ-009 req_rd_i  in  5  destination register index.
REQ-010 mem_req_o  out  1  memory read request.
REQ-011 mem_addr_o  out  XLEN  word-aligned read address (low log2(B) bits zero).
REQ-012 mem_gnt_i  in  1  memory accepts request this cycle.
REQ-013 mem_rvalid_i  in  1  read data valid.
REQ-014 mem_rdata_i  in  XLEN  read data, little-endian.
REQ-015 wb_valid_o  out  1  writeback valid.
REQ-016 wb_ready_i  in  1  writeback accepted.
REQ-017 wb_rd_o  out  5  destination register.
REQ-018 wb_data_o  out  XLEN  aligned, extended load result.
REQ-019 fault_o  out  1  valid with wb_valid_o; request faulted.

Function
REQ-020 Size S = 1 << funct3[1:0] bytes; offset O = addr mod B; access is split when O+S > B.
REQ-021 Fault if funct3 = 111, or XLEN=32 with funct3 in {011,110}, or split with MISALIGN_EN=0.
REQ-022 FSM states IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP; reset state IDLE.
REQ-023 IDLE: req_ready_o=1 (0 in all other states); on req_valid_i, latch addr/funct3/rd; fault -> RESP, else -> REQ0.
REQ-024 REQ0: mem_req_o=1, mem_addr_o = addr with low log2(B) bits cleared; held stable until mem_gnt_i; on grant -> WAIT0.
REQ-025 WAIT0: on mem_rvalid_i, store beat0; split -> REQ1, else -> RESP with result computed.
REQ-026 REQ1: mem_req_o=1, mem_addr_o = aligned address + B modulo 2^XLEN (wrap to 0 permitted); on grant -> WAIT1.
REQ-027 WAIT1: on mem_rvalid_i, merge {beat1, beat0}, -> RESP.
REQ-028 Merge: take {beat1,beat0} (beat1 = 0 if not split), shift right by 8*O, keep low S bytes; funct3[2]=0 sign-extends, 1 zero-extends to XLEN.
REQ-029 RESP: wb_valid_o=1; wb_rd_o, wb_data_o, fault_o held stable until wb_ready_i; on wb_ready_i -> IDLE.
REQ-030 Faulted request: no memory request issued, wb_data_o=0, fault_o=1.
REQ-031 mem_gnt_i ignored outside REQ0/REQ1; mem_rvalid_i ignored outside WAIT0/WAIT1.
REQ-032 Minimum latency with same-cycle grant and next-cycle rvalid: accept cycle N -> wb_valid_o at N+3 (aligned), N+5 (split).
REQ-033 A new request is not accepted in the cycle RESP completes; earliest next accept is the following cycle.

Reset
REQ-034 On reset: state IDLE, req_ready_o=1; mem_req_o, wb_valid_o, fault_o=0; mem_addr_o, wb_rd_o, wb_data_o=0; latched beats cleared.
REQ-035 Reset mid-operation aborts the load, produces no writeback, and ignores any later rvalid for the aborted request.

Verification
REQ-036 XLEN=32, LW 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF -> one read at 0x100; wb_data_o=0xDEADBEEF, fault_o=0, wb_valid_o at N+3.
REQ-037 LB 0x103, rdata 0x80123456 -> wb_data_o=0xFFFFFF80; LBU same -> 0x00000080; LHU 0x102 -> 0x00008012.
REQ-038 LW 0x102, beat0 @0x100 = 0x11223344, beat1 @0x104 = 0x55667788 -> reads 0x100 then 0x104; wb_data_o=0x77881122 at N+5.
REQ-039 LH 0xFFFFFFFF, beat0 = 0xAB000000, beat1 @0x00000000 = 0x000000CD -> second address 0x00000000; wb_data_o=0xFFFFCDAB.
REQ-040 MISALIGN_EN=0 LW 0x101, and XLEN=32 LD 0x0 -> mem_req_o never asserted; fault_o=1, wb_data_o=0.
REQ-041 wb_ready_i low 3 cycles in RESP -> outputs stable, req_ready_o=0; reset during WAIT1 -> next cycle all outputs at reset values; late rvalid produces no writeback.
